// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Sits between the pipeline MEM stage (ready/valid) and a word-wide data
// memory with asynchronous read data. Lines are evicted and filled one word
// per cycle; the pipeline stalls by holding its request until cpu_dout_valid.
module dmem_cache_ctrl #(
   parameter int NUM_SETS       = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_din,
   input  logic        cpu_read,
   input  logic        cpu_write,
   output logic        cpu_ready,
   output logic [31:0] cpu_dout,
   output logic        cpu_dout_valid,
   output logic        cpu_hit,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_dout
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int OFF_W = $clog2(WORDS_PER_LINE);
   localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      WB,
      FILL
   } state_t;

   state_t state;

   logic [OFF_W-1:0] cnt;
   logic [29:0]      req_word_addr;   // captured word address (byte bits dropped)
   logic [31:0]      req_din;
   logic             req_write;
   logic             miss_flag;       // set by a completed fill, marks the post-fill lookup

   logic [NUM_SETS-1:0] valid_q;
   logic [NUM_SETS-1:0] dirty_q;
   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   logic [31:0]         data_q [NUM_SETS][WORDS_PER_LINE];

   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic [OFF_W-1:0] req_off;
   logic             hit;
   logic             fill_last;

   // Byte-select bits of the CPU address carry no information for word accesses.
   logic unused_byte_bits;
   assign unused_byte_bits = ^cpu_addr[1:0];

   assign req_off   = req_word_addr[0 +: OFF_W];
   assign req_idx   = req_word_addr[OFF_W +: IDX_W];
   assign req_tag   = req_word_addr[29 -: TAG_W];
   assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign fill_last = (cnt == LAST_WORD);

   // Output decode from the registered state; everything is forced to 0 under reset.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
      cpu_ready      = 1'b0;
      cpu_dout       = '0;
      cpu_dout_valid = 1'b0;
      cpu_hit        = 1'b0;
      mem_addr       = '0;
      mem_din        = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      if (!reset) begin
         unique case (state)
            IDLE: cpu_ready = 1'b1;
            LOOKUP: begin
               if (hit) begin
                  cpu_dout_valid = 1'b1;
                  cpu_dout       = data_q[req_idx][req_off];
                  cpu_hit        = !miss_flag;
               end
            end
            WB: begin
               mem_write = 1'b1;
               mem_addr  = {tag_q[req_idx], req_idx, cnt, 2'b00};
               mem_din   = data_q[req_idx][cnt];
            end
            FILL: begin
               mem_read = 1'b1;
               mem_addr = {req_tag, req_idx, cnt, 2'b00};
            end
            default: ;
         endcase
      end
   end

   // Controller FSM: request capture, lookup decision, write-back and fill sequencing.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         req_word_addr <= '0;
         req_din       <= '0;
         req_write     <= 1'b0;
         miss_flag     <= 1'b0;
         valid_q       <= '0;
         dirty_q       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cpu_req && (cpu_read || cpu_write)) begin
                  req_word_addr <= cpu_addr[31:2];
                  req_din       <= cpu_din;
                  req_write     <= cpu_write;   // a store wins if both op bits are set
                  state         <= LOOKUP;
               end
            end
            LOOKUP: begin
               cnt <= '0;
               if (hit) begin
                  miss_flag <= 1'b0;
                  if (req_write) dirty_q[req_idx] <= 1'b1;
                  state <= IDLE;
               end else begin
                  // The line is invalid from here until the last fill word lands.
                  valid_q[req_idx] <= 1'b0;
                  state <= (valid_q[req_idx] && dirty_q[req_idx]) ? WB : FILL;
               end
            end
            WB: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST_WORD) begin
                  cnt   <= '0;
                  state <= FILL;
               end
            end
            FILL: begin
               cnt <= cnt + 1'b1;
               if (fill_last) begin
                  cnt              <= '0;
                  valid_q[req_idx] <= 1'b1;
                  dirty_q[req_idx] <= 1'b0;
                  miss_flag        <= 1'b1;
                  state            <= LOOKUP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag and data arrays: store-hit writes and fill writes.
   always_ff @(posedge clk) begin
      // NOTE: the arrays are deliberately not reset; valid_q alone decides whether their contents mean anything.
      if (!reset) begin
         if (state == LOOKUP && hit && req_write)
            data_q[req_idx][req_off] <= req_din;
         if (state == FILL) begin
            data_q[req_idx][cnt] <= mem_dout;
            if (fill_last) tag_q[req_idx] <= req_tag;
         end
      end
   end

endmodule

// File: tb/tb_dmem_cache_ctrl.sv
// Self-checking bench for dmem_cache_ctrl: directed scenarios followed by
// randomized loads/stores, checked against a set/tag model of the cache and a
// flat CPU-visible memory image.
module tb_dmem_cache_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_din;
   logic        cpu_read;
   logic        cpu_write;
   logic        cpu_ready;
   logic [31:0] cpu_dout;
   logic        cpu_dout_valid;
   logic        cpu_hit;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_dout;

   int n_checks = 0;
   int n_errors = 0;

   dmem_cache_ctrl #(.NUM_SETS(16), .WORDS_PER_LINE(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_req        (cpu_req),
      .cpu_addr       (cpu_addr),
      .cpu_din        (cpu_din),
      .cpu_read       (cpu_read),
      .cpu_write      (cpu_write),
      .cpu_ready      (cpu_ready),
      .cpu_dout       (cpu_dout),
      .cpu_dout_valid (cpu_dout_valid),
      .cpu_hit        (cpu_hit),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_dout       (mem_dout)
   );

   always #5 clk = ~clk;

   // Backing data memory: asynchronous read, write on posedge.
   logic [31:0] mem [0:1023];
   assign mem_dout = mem[mem_addr[11:2]];

   // Memory write port.
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[11:2]] <= mem_din;
   end

   // Reference model: what the CPU should see, plus which line each set holds.
   logic [31:0] ref_mem [0:1023];
   bit          m_valid [16];
   bit          m_dirty [16];
   int unsigned m_tag   [16];

   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] all_outputs();
      return {24'd0, cpu_ready, cpu_dout_valid, cpu_hit, mem_read, mem_write,
              |cpu_dout, |mem_addr, |mem_din};
   endfunction

   // One CPU transaction, entered and left at a negedge with the DUT in IDLE.
   task automatic do_req(input logic [31:0] addr, input logic [31:0] din,
                         input logic rd, input logic wr);
      int unsigned line, set, tg, word, vbase, lbase;
      bit          exp_hit, vic_dirty;
      int          exp_lat, rd_start, cyc;
      bit          done, proto_ok;
      logic [31:0] got_dout;
      logic        got_hit;
      ev_t         rq[$], wq[$], erq[$], ewq[$];
      ev_t         e;

      line      = addr / 16;
      set       = line % 16;
      tg        = line / 16;
      word      = addr / 4;
      lbase     = line * 4;
      exp_hit   = m_valid[set] && (m_tag[set] == tg);
      vic_dirty = !exp_hit && m_valid[set] && m_dirty[set];
      exp_lat   = exp_hit ? 1 : (vic_dirty ? 10 : 6);
      rd_start  = vic_dirty ? 6 : 2;
      if (vic_dirty) begin
         vbase = (m_tag[set] * 16 + set) * 4;
         for (int k = 0; k < 4; k++) begin
            e.cyc = 2 + k; e.a = (vbase + k) * 4; e.d = ref_mem[vbase + k];
            ewq.push_back(e);
         end
      end
      if (!exp_hit) begin
         for (int k = 0; k < 4; k++) begin
            e.cyc = rd_start + k; e.a = (lbase + k) * 4; e.d = 0;
            erq.push_back(e);
         end
      end

      check("ready_idle", {31'd0, cpu_ready}, 32'd1);
      cpu_req = 1'b1; cpu_addr = addr; cpu_din = din; cpu_read = rd; cpu_write = wr;
      @(posedge clk);
      cyc = 0; done = 0; proto_ok = 1; got_dout = '0; got_hit = 1'b0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (mem_read && mem_write) proto_ok = 0;
         if (!mem_read && !mem_write && (mem_addr != 0 || mem_din != 0)) proto_ok = 0;
         if (!cpu_dout_valid && (cpu_dout != 0 || cpu_hit)) proto_ok = 0;
         if (cpu_ready) proto_ok = 0;
         if (mem_read)  begin e.cyc = cyc; e.a = mem_addr; e.d = 0;       rq.push_back(e); end
         if (mem_write) begin e.cyc = cyc; e.a = mem_addr; e.d = mem_din; wq.push_back(e); end
         if (cpu_dout_valid) begin
            done = 1; got_dout = cpu_dout; got_hit = cpu_hit;
         end
      end
      cpu_req = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
      check("done", {31'd0, done}, 32'd1);
      check("latency", cyc, exp_lat);
      check("hit", {31'd0, got_hit}, {31'd0, exp_hit});
      check("protocol", {31'd0, proto_ok}, 32'd1);
      if (!wr) check("rdata", got_dout, ref_mem[word]);
      check("n_mem_read", rq.size(), erq.size());
      check("n_mem_write", wq.size(), ewq.size());
      for (int i = 0; i < rq.size() && i < erq.size(); i++) begin
         check("rd_cycle", rq[i].cyc, erq[i].cyc);
         check("rd_addr", rq[i].a, erq[i].a);
      end
      for (int i = 0; i < wq.size() && i < ewq.size(); i++) begin
         check("wb_cycle", wq[i].cyc, ewq[i].cyc);
         check("wb_addr", wq[i].a, ewq[i].a);
         check("wb_data", wq[i].d, ewq[i].d);
      end

      if (!exp_hit) begin
         m_valid[set] = 1; m_tag[set] = tg; m_dirty[set] = 0;
      end
      if (wr) begin
         ref_mem[word] = din;
         m_dirty[set]  = 1;
      end
      @(negedge clk);
   endtask

   initial begin
      bit          quiet;
      logic [31:0] addr;
      int          op;

      reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_din = '0;
      cpu_read = 1'b0; cpu_write = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[32'h41] = 32'hAAAA0001;
      mem[32'h42] = 32'hAAAA0002;
      for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
      for (int s = 0; s < 16; s++) begin m_valid[s] = 0; m_dirty[s] = 0; m_tag[s] = 0; end

      repeat (2) @(negedge clk);
      check("outputs_in_reset", all_outputs(), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {31'd0, cpu_ready}, 32'd1);
      check("valid_after_reset", {31'd0, cpu_dout_valid}, 32'd0);

      // Directed scenarios from the block's intended use.
      do_req(32'h104, 32'h0, 1'b1, 1'b0);
      do_req(32'h108, 32'h0, 1'b1, 1'b0);
      do_req(32'h10C, 32'hDEADBEEF, 1'b0, 1'b1);
      do_req(32'h10C, 32'h0, 1'b1, 1'b0);
      do_req(32'h20C, 32'h0, 1'b1, 1'b0);
      check("mem_word_43", mem[32'h43], 32'hDEADBEEF);
      do_req(32'h304, 32'h12345678, 1'b0, 1'b1);
      do_req(32'h304, 32'h0, 1'b1, 1'b0);
      do_req(32'h004, 32'h0, 1'b1, 1'b0);
      check("mem_word_c1", mem[32'hC1], 32'h12345678);

      // A request with no op bits must be ignored.
      cpu_req = 1'b1; cpu_addr = 32'h208;
      quiet = 1;
      repeat (3) begin
         @(negedge clk);
         if (!cpu_ready || mem_read || mem_write || cpu_dout_valid) quiet = 0;
      end
      cpu_req = 1'b0;
      check("no_op_ignored", {31'd0, quiet}, 32'd1);

      // Reset during the third fill cycle abandons the miss.
      cpu_req = 1'b1; cpu_addr = 32'h104; cpu_read = 1'b1;
      @(posedge clk);
      repeat (4) @(negedge clk);
      check("fill_active", {31'd0, mem_read}, 32'd1);
      reset = 1'b1; cpu_req = 1'b0; cpu_read = 1'b0;
      quiet = 1;
      repeat (2) begin
         @(negedge clk);
         if (all_outputs() != 0) quiet = 0;
      end
      check("outputs_mid_reset", {31'd0, quiet}, 32'd1);
      reset = 1'b0;
      for (int s = 0; s < 16; s++) begin m_valid[s] = 0; m_dirty[s] = 0; end
      quiet = 1;
      repeat (3) begin
         @(negedge clk);
         if (!cpu_ready || mem_read || mem_write) quiet = 0;
      end
      check("quiet_after_reset", {31'd0, quiet}, 32'd1);
      do_req(32'h104, 32'h0, 1'b1, 1'b0);

      // Randomized traffic over a few sets and tags to force hits, conflicts and write-backs.
      for (int n = 0; n < 300; n++) begin
         addr = ($urandom_range(0, 3) * 256) + ($urandom_range(0, 3) * 16)
              + ($urandom_range(0, 3) * 4) + $urandom_range(0, 3);
         op = $urandom_range(0, 3);
         do_req(addr, $urandom, (op != 2), (op >= 2));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_cache_ctrl.md
Name: dmem_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache sitting between the pipeline MEM stage and the word-wide data memory.
- Initiator side of the data-memory interface: drives addr/din/mem_read/mem_write, samples the asynchronous read data.
- Fills and evicts whole lines one word per cycle; CPU side uses a ready/valid handshake so the pipeline stalls on a miss.

Parameters:
NUM_SETS, 16, number of cache lines; power of two; index width = log2(NUM_SETS)
WORDS_PER_LINE, 4, 32-bit words per line; power of two; word-offset width = log2(WORDS_PER_LINE)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
cpu_req  input  1  request valid from pipeline
cpu_addr  input  32  byte address; bits [1:0] ignored
cpu_din  input  32  write data
cpu_read  input  1  request is a load
cpu_write  input  1  request is a store
cpu_ready  output  1  controller idle, can accept a request this cycle
cpu_dout  output  32  load data, valid when cpu_dout_valid
cpu_dout_valid  output  1  request complete this cycle (loads and stores)
cpu_hit  output  1  qualifies cpu_dout_valid: 1 = hit, 0 = serviced via miss
mem_addr  output  32  byte address to data memory
mem_din  output  32  write data to data memory
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable
mem_dout  input  32  asynchronous read data from memory

Behaviour:
- Address split (defaults): [1:0] byte, [3:2] word offset, [7:4] index, [31:8] tag.
- Storage: valid, dirty, tag and data arrays in registers; whole-word writes only.
- Reset (clk edge with reset=1): all valid/dirty bits cleared, state IDLE, word counter 0, captured request cleared.
- While reset is high, all outputs are 0, including cpu_ready.
- Reset mid-operation abandons the transaction:
  - no further mem_write is issued;
  - the partially filled line stays invalid.
- States: IDLE, LOOKUP, WB, FILL.
- IDLE:
  - cpu_ready=1.
  - Accept when cpu_req && (cpu_read || cpu_write): capture addr, din and op; go to LOOKUP.
  - Write has priority if both op bits are set.
  - cpu_req with neither op bit set is ignored.
- LOOKUP:
  - cpu_ready=0; hit = valid[idx] && tag[idx]==req_tag.
  - On hit: cpu_dout_valid=1; cpu_dout = line word; cpu_hit=1 unless this is the post-fill lookup, which gives cpu_hit=0.
  - Store on hit: word written and dirty set at the edge ending LOOKUP.
  - After a hit: go to IDLE.
  - Miss, victim dirty: go to WB, counter=0.
  - Miss, victim clean or invalid: go to FILL, counter=0.
- WB:
  - mem_write=1; mem_addr = {victim tag, idx, k, 2'b00}; mem_din = line word k.
  - After k = WORDS_PER_LINE-1: go to FILL, counter=0.
- FILL:
  - mem_read=1; mem_addr = {req tag, idx, k, 2'b00}.
  - mem_dout is stored into line word k at the posedge.
  - After last word: valid=1, tag=req tag, dirty=0, miss flag set; return to LOOKUP.
  - Post-fill LOOKUP always hits; reports cpu_hit=0; clears the miss flag.
- Latency, with acceptance at edge E0 and cycles counted after it:
  - hit: valid in cycle 1;
  - clean miss: valid in cycle 6;
  - dirty miss: valid in cycle 10.
- Inactive values:
  - cpu_dout = 0 when cpu_dout_valid=0;
  - mem_addr and mem_din = 0 when mem_read=0 and mem_write=0;
  - mem_read and mem_write are never both 1.
- cpu_req outside IDLE is ignored; the pipeline must hold the request until cpu_dout_valid.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after cpu_dout_valid.

Test Plan:
- Memory preloaded word[0x41]=0xAAAA0001, word[0x42]=0xAAAA0002; after reset, read 0x104 -> mem_read at 0x100, 0x104, 0x108, 0x10C in cycles 2-5; cycle 6 cpu_dout=0xAAAA0001, cpu_hit=0.
- Then read 0x108 -> cycle 1 cpu_dout=0xAAAA0002, cpu_hit=1, mem_read never asserted.
- Write 0x10C=0xDEADBEEF -> hit in cycle 1, no mem_write; read 0x10C -> 0xDEADBEEF, hit=1.
- Read 0x20C (same index, tag 2) -> mem_write at 0x100-0x10C in cycles 2-5 with the last word 0xDEADBEEF; mem_read at 0x200-0x20C in cycles 6-9; valid in cycle 10, hit=0; memory word[0x43]=0xDEADBEEF.
- Write miss 0x304=0x12345678 over the clean line -> no WB, fill 0x300-0x30C, valid in cycle 6 with hit=0; read 0x304 -> hit, 0x12345678; later read 0x004 -> WB writes 0x12345678 to byte address 0x304.
- Assert reset during FILL cycle 3 -> outputs 0 during reset, no further mem_read or mem_write; then read 0x104 -> full miss again, valid in cycle 6.
